// File: rtl/misc_mem_pkg.sv
// Shared constants and types for the MISC 16-bit core data RAM and its dump reader.
package misc_mem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 256;

    localparam logic [DATA_W-1:0] EXP_INIT_VAL = '0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } dump_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dump_word_t;

endpackage

// File: rtl/ram_dump_reader_if.sv
// RAM read port plus valid/ready output stream of the dump reader.
interface ram_dump_reader_if;
    import misc_mem_pkg::*;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rd_data,
        output out_valid, out_addr, out_data,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rd_data,
        input  out_valid, out_addr, out_data,
        output out_ready
    );

endinterface

// File: rtl/dump_skid_fifo.sv
// 2-entry FIFO holding captured {addr, data} words; push and pop may coincide.
module dump_skid_fifo #(
    parameter int unsigned Width = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);
    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_dump_reader.sv
// Walks the whole data RAM and streams {addr, data} pairs out through a 2-entry buffer.
// Build option RAM_DUMP_CHECK_EN adds a compare against the initialisation value.
module ram_dump_reader
    import misc_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    ram_dump_reader_if.master bus
);
    dump_state_e       state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              rd_en, pop;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [2:0]        occ_sum;
    dump_word_t        head, push_word;

    // Room check counts buffered words plus the read whose data is on the bus now.
    assign pop       = fifo_valid & bus.out_ready;
    assign occ_sum   = {1'b0, fifo_count} + {2'b0, pend_q} - {2'b0, pop};
    assign rd_en     = (state_q == StRun) && (occ_sum < 3'd2);
    assign push_word = '{addr: pend_addr_q, data: bus.mem_rd_data};

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        pend_d      = rd_en;
        pend_addr_d = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                end
            end
            StRun: begin
                if (rd_en) begin
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (fifo_count == 2'd0 && !pend_q) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    dump_skid_fifo #(
        .Width($bits(dump_word_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (pend_q),
        .push_data_i(push_word),
        .pop_i      (pop),
        .head_o     (head),
        .valid_o    (fifo_valid),
        .count_o    (fifo_count)
    );

`ifdef RAM_DUMP_CHECK_EN
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Only the first nonzero capture is recorded; a fresh dump clears the flag.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (state_q == StIdle && start) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (pend_q && !err_q && push_word.data != EXP_INIT_VAL) begin
            err_d      = 1'b1;
            err_addr_d = pend_addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_addr  = head.addr;
    assign bus.out_data  = head.data;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader: RAM model, scoreboard queue of expected words.
module tb_ram_dump_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_addr;

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [15:0] ram [256];
    logic [23:0] exp_q [$];

    ram_dump_reader_if bus ();

    ram_dump_reader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_addr(err_addr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_out_addr"}, 32'(bus.out_addr), 0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 0);
        chk({tag, "_err_addr"}, 32'(err_addr), 0);
    endtask

    task automatic push_exp();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] a8;
            a8 = 8'(a);
            exp_q.push_back({a8, ram[a]});
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic wait_size(input int lim, input int bound, output bit ok);
        int n = 0;
        while (exp_q.size() > lim && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (exp_q.size() <= lim);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        push_exp();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: scoreboard pops, stall stability, occupancy model and done counting.
    initial begin
        int          occ_m;
        int          infl_m;
        bit          hold_v;
        bit          pop_now;
        logic [23:0] hold_w;
        logic [23:0] w;
        occ_m  = 0;
        infl_m = 0;
        hold_v = 1'b0;
        hold_w = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                occ_m  = 0;
                infl_m = 0;
                hold_v = 1'b0;
            end else begin
                pop_now = bus.out_valid && bus.out_ready;
                if (hold_v)
                    chk("stall_stable", {7'b0, bus.out_valid, bus.out_addr, bus.out_data},
                        {8'h01, hold_w});
                chk("valid_vs_occ", 32'(bus.out_valid), 32'(occ_m != 0));
                if (bus.mem_rd_en)
                    chk("rd_room", 32'((occ_m + infl_m - int'(pop_now)) < 2), 1);
                if (pop_now) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", {8'h0, bus.out_addr, bus.out_data}, 32'hFFFF_FFFF);
                    end else begin
                        w = exp_q.pop_front();
                        chk("word", {8'h0, bus.out_addr, bus.out_data}, {8'h0, w});
                    end
                end
                if (done) done_cnt++;
                occ_m  = occ_m + infl_m - int'(pop_now);
                infl_m = int'(bus.mem_rd_en);
                hold_v = bus.out_valid && !bus.out_ready;
                hold_w = {bus.out_addr, bus.out_data};
            end
        end
    end

    initial begin
        bit ok;
        int t0;
        int dn0;
        bit restarted;
        int n;

        rst           = 1'b1;
        start         = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 16'(i) ^ 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Full-speed dump: first word, latency and done timing.
        @(posedge clk); #1;
        start = 1'b1;
        push_exp();
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc;
        chk("e0_busy", 32'(busy), 1);
        chk("e0_rd_en", 32'(bus.mem_rd_en), 1);
        chk("e0_mem_addr", 32'(bus.mem_addr), 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("e1_valid", 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk("e2_valid", 32'(bus.out_valid), 1);
        chk("e2_word0", {8'h0, bus.out_addr, bus.out_data}, 32'h0000_A5A5);
        wait_done(400, ok);
        chk("t1_done_seen", 32'(ok), 1);
        chk("t1_done_latency", 32'(cyc - t0), 259);
        chk("t1_busy_with_done", 32'(busy), 0);
        chk("t1_all_words", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(done), 0);

        // Random backpressure with a stray start at word 100.
        dn0 = done_cnt;
        pulse_start();
        restarted = 1'b0;
        n         = 0;
        while (done !== 1'b1 && n < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!restarted && exp_q.size() <= 156) begin
                start     = 1'b1;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("t2_done_seen", 32'(done), 1);
        chk("t2_all_words", 32'(exp_q.size()), 0);
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t2_single_done", 32'(done_cnt - dn0), 1);
        chk("t2_idle", 32'(busy), 0);

        // Reset at word 50, then a clean restart from address 0.
        pulse_start();
        wait_size(206, 400, ok);
        chk("t3_reach_50", 32'(ok), 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        dn0 = done_cnt;
        pulse_start();
        wait_done(400, ok);
        chk("t3_done_seen", 32'(ok), 1);
        chk("t3_all_words", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        chk("t3_single_done", 32'(done_cnt - dn0), 1);

        // Mostly-zero RAM: the checker must latch the first bad address only.
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h3C] = 16'h0001;
        ram[8'h80] = 16'h0002;
        pulse_start();
        wait_size(256 - 8'h30, 400, ok);
        chk("t4_reach_30", 32'(ok), 1);
        chk("t4_err_early", 32'(err), 0);
        wait_done(400, ok);
        chk("t4_done_seen", 32'(ok), 1);
`ifdef RAM_DUMP_CHECK_EN
        chk("t4_err", 32'(err), 1);
        chk("t4_err_addr", 32'(err_addr), 32'h3C);
`else
        chk("t4_err", 32'(err), 0);
        chk("t4_err_addr", 32'(err_addr), 0);
`endif
        @(posedge clk); #1;
        pulse_start();
        chk("t4_err_cleared", 32'(err), 0);
        wait_done(400, ok);
        chk("t4b_done_seen", 32'(ok), 1);
        chk("t4b_all_words", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_dump_reader.md
# ram_dump_reader

Sequential read-out engine for the 256 x 16-bit data RAM of the MISC 16-bit core, and the read-side counterpart of the RAM initialisation block. On `start` it walks every address from 0 to DEPTH-1, issues synchronous reads to the RAM read port, and streams `{addr, data}` pairs out over a valid/ready interface with a 2-entry buffer, so downstream backpressure never drops a word. The debug/dump path uses it to read out memory after reset or after a program run.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 16, RAM word width
- `DEPTH`, 256, number of words walked; must equal 2**ADDR_W
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the last word is accepted downstream
- `mem_rd_en`  out  1  RAM read strobe
- `mem_addr`  out  ADDR_W  RAM read address
- `mem_rd_data`  in  DATA_W  RAM read data, valid one cycle after `mem_rd_en`
- `out_valid`  out  1  output word available
- `out_ready`  in  1  downstream accepts the word when both `out_valid` and `out_ready` are high
- `out_addr`  out  ADDR_W  address of the presented word
- `out_data`  out  DATA_W  presented word
- `err`  out  1  sticky mismatch flag (check build only)
- `err_addr`  out  ADDR_W  first mismatching address (check build only)

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the read of DEPTH-1 is issued.
  - DRAIN → DONE when the buffer is empty and no read is in flight.
  - DONE → IDLE unconditionally (one cycle; `done`=1).
- Read issue: in RUN, a read is issued when (buffer occupancy + reads in flight − pop this cycle) < 2. `mem_addr` then increments, 8-bit, with no wrap past DEPTH-1.
- Capture: the cycle after `mem_rd_en`, `mem_rd_data` and its address are written into the buffer.
- Buffer: 2-entry FIFO in address order. The head drives `out_*`. Push and pop can happen in the same cycle. Overflow is impossible by construction.
- `start` while `busy` is ignored and has no side effects.
- `mem_rd_en`=0 and `mem_addr` is held in IDLE, DRAIN and DONE.
- Reset values: state IDLE; `busy`, `done`, `mem_rd_en`, `out_valid` and `err` = 0; `mem_addr`, `out_addr`, `out_data` and `err_addr` = 0; buffer empty; no read in flight.
- Reset mid-dump discards buffered words and in-flight reads. No `done` is produced.

## Timing
- `start` sampled at edge E0: `busy`=1, `mem_rd_en`=1, `mem_addr`=0 after E0.
- Read data is captured at E2, and `out_valid` goes high after E2, so first-word latency is 2 cycles.
- With `out_ready` held high: one word per cycle. A full dump takes DEPTH+3 cycles from `start` to the `done` pulse.
- With `out_ready` low: at most 2 words are buffered, `mem_rd_en` stalls, and `out_*` stays stable until accepted.
- `done` is asserted the cycle after the acceptance of address DEPTH-1. `busy` drops together with `done`.

## Configuration
- Macro `RAM_DUMP_CHECK_EN`.
- Defined: each captured word is compared against the expected initialisation value 0.
  - On the first nonzero word, `err`=1 and `err_addr` records that address.
  - `err` holds until the next accepted `start` or `rst`.
- Undefined: no comparator is built, and `err`/`err_addr` are tied to 0.

## Structure
- Shared package `misc_mem_pkg` holds:
  - `ADDR_W`, `DATA_W`, `DEPTH`
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - the expected initialisation value constant (0)
- One sub-module, `dump_skid_fifo`: a 2-entry, `ADDR_W+DATA_W`-wide FIFO with push/pop/occupancy.

## Test plan
- RAM model holds data = addr ^ 16'hA5A5; pulse `start`, `out_ready`=1 → 256 words in order; word 0 is `out_addr`=0, `out_data`=16'hA5A5. `done` pulses exactly 259 cycles after `start`.
- `out_ready` toggles randomly → no word is lost or duplicated, `out_*` is stable while stalled, and `mem_rd_en` is never high while occupancy+in-flight = 2.
- `start` pulsed again at word 100 → ignored; the sequence continues, with a single `done`.
- `rst` asserted at word 50 → all outputs are 0 in the same cycle; a new `start` restarts from address 0.
- Check build, RAM all zero except addr 8'h3C=16'h0001 and 8'h80=16'h0002 → `err`=1 at the capture of 0x3C and `err_addr`=8'h3C (not 0x80). `err` clears on the next `start`.
- Non-check build, same RAM → `err`=0 throughout.
